// File: rtl/wb_pkg.sv
// Shared types and helpers for the write-back sequencer: FSM state encoding,
// write-back mux select codes and the source normalization function.
package wb_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        WAIT_MEM = 2'b01,
        WRITE    = 2'b10
    } wb_state_t;

    localparam logic [1:0] WB_SEL_MEM = 2'b00;
    localparam logic [1:0] WB_SEL_ALU = 2'b01;
    localparam logic [1:0] WB_SEL_PC4 = 2'b10;

    // Encoding 11 is an alias of PC+4, so the mux only ever sees three codes.
    function automatic logic [1:0] wb_norm_sel(input logic [1:0] sel);
        return (sel == 2'b11) ? WB_SEL_PC4 : sel;
    endfunction

endpackage

// File: rtl/wb_timeout_ctr.sv
// Load-response watchdog: clearable, enabled up-counter that flags the cycle
// in which it holds MEM_TIMEOUT-1.
module wb_timeout_ctr #(
    parameter int MEM_TIMEOUT = 64
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_clear,
    input  logic i_enable,
    output logic o_tc
);

    localparam int CW = (MEM_TIMEOUT > 2) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] TC_VAL = CW'(MEM_TIMEOUT - 1);

    logic [CW-1:0] r_count;

    // Clear wins over enable so a fresh load always starts from zero.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_enable) begin
            r_count <= r_count + CW'(1);
        end
    end

    assign o_tc = (r_count == TC_VAL);

endmodule

// File: rtl/wb_ctrl.sv
// Write-back sequencer for the single register-file write port: accepts one
// retiring instruction, waits for load data if needed, then issues one write.
module wb_ctrl
    import wb_pkg::*;
#(
    parameter int MEM_TIMEOUT = 64,
    parameter int CNT_W       = 32
) (
    input  logic             i_clk,
    input  logic             i_reset,
    input  logic             i_issue_valid,
    output logic             o_issue_ready,
    input  logic [4:0]       i_issue_rd,
    input  logic [1:0]       i_issue_sel,
    input  logic             i_mem_rsp_valid,
    input  logic             i_flush,
    output logic [1:0]       o_sel_wb,
    output logic             o_rf_we,
    output logic [4:0]       o_rf_waddr,
    output logic             o_wb_timeout,
    output logic [CNT_W-1:0] o_retire_cnt
);

    wb_state_t        r_state;
    wb_state_t        w_next_state;

    logic [4:0]       r_rd;
    logic [1:0]       r_sel;
    logic [1:0]       r_sel_wb;
    logic             r_rf_we;
    logic [4:0]       r_rf_waddr;
    logic             r_wb_timeout;
    logic [CNT_W-1:0] r_retire_cnt;

    logic             w_issue_ready;
    logic             w_accept;
    logic [1:0]       w_acc_sel;
    logic             w_rsp_ok;
    logic             w_load_wr;
    logic [4:0]       w_wr_rd;
    logic [1:0]       w_wr_sel;
    logic             w_ctr_en;
    logic             w_timeout_set;
    logic             w_tc;

    wb_timeout_ctr #(
        .MEM_TIMEOUT(MEM_TIMEOUT)
    ) u_timeout_ctr (
        .i_clk    (i_clk),
        .i_reset  (i_reset),
        .i_clear  (w_accept),
        .i_enable (w_ctr_en),
        .o_tc     (w_tc)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Flush always lands in IDLE; an in-progress WRITE has already been
    // registered onto the port, so only the follow-on accept is lost.
    always_comb begin
        w_next_state = r_state;
        if (i_flush) begin
            w_next_state = IDLE;
        end else begin
            case (r_state)
                IDLE, WRITE: begin
                    if (w_accept) begin
                        w_next_state = (w_acc_sel == WB_SEL_MEM) ? WAIT_MEM : WRITE;
                    end else begin
                        w_next_state = IDLE;
                    end
                end
                WAIT_MEM: begin
                    if (i_mem_rsp_valid) begin
                        w_next_state = WRITE;
                    end else if (w_tc) begin
                        w_next_state = IDLE;
                    end
                end
                default: w_next_state = IDLE;
            endcase
        end
    end

    always_comb begin
        w_issue_ready = !i_reset && !i_flush && (r_state != WAIT_MEM);
        w_accept      = i_issue_valid && w_issue_ready;
        w_acc_sel     = wb_norm_sel(i_issue_sel);
        w_rsp_ok      = (r_state == WAIT_MEM) && i_mem_rsp_valid && !i_flush;
        w_load_wr     = (w_accept && (w_acc_sel != WB_SEL_MEM)) || w_rsp_ok;
        w_wr_rd       = w_accept ? i_issue_rd : r_rd;
        w_wr_sel      = w_accept ? w_acc_sel : r_sel;
        w_ctr_en      = (r_state == WAIT_MEM) && !i_mem_rsp_valid && !i_flush;
        w_timeout_set = w_ctr_en && w_tc;
    end

    // Write-port registers are loaded on the edge that enters WRITE, so the
    // strobe, address and select all appear together during WRITE.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_rd         <= '0;
            r_sel        <= WB_SEL_ALU;
            r_sel_wb     <= WB_SEL_ALU;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_wb_timeout <= 1'b0;
            r_retire_cnt <= '0;
        end else begin
            r_rf_we <= w_load_wr && (w_wr_rd != 5'd0);
            if (w_load_wr) begin
                r_rf_waddr <= w_wr_rd;
                r_sel_wb   <= w_wr_sel;
            end
            if (w_accept) begin
                r_rd  <= i_issue_rd;
                r_sel <= w_acc_sel;
            end
            if (w_timeout_set) begin
                r_wb_timeout <= 1'b1;
            end
            if (r_rf_we) begin
                r_retire_cnt <= r_retire_cnt + CNT_W'(1);
            end
        end
    end

    assign o_issue_ready = w_issue_ready;
    assign o_sel_wb      = r_sel_wb;
    assign o_rf_we       = r_rf_we;
    assign o_rf_waddr    = r_rf_waddr;
    assign o_wb_timeout  = r_wb_timeout;
    assign o_retire_cnt  = r_retire_cnt;

endmodule
